// File: rtl/fifo_write_arbiter_pkg.sv
// rtl/fifo_write_arbiter_pkg.sv - shared state encoding and sizing helpers for fifo_write_arbiter
package fifo_write_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Word counter only needs to reach max_block-1; never narrower than one bit.
    function automatic int cnt_width(input int max_block);
        return (max_block > 2) ? $clog2(max_block) : 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rtl/fifo_write_arbiter_rr_pick.sv - combinational round-robin picker, searching upward from ptr+1
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] sel,
    output logic             any
);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        sel   = '0;
        any   = 1'b0;
        w_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!any && req[w_idx]) begin
                sel[w_idx] = 1'b1;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - block-granular round-robin sharing of one FIFO write port
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int N_REQ          = 4,
    parameter int MAX_BLOCK_SIZE = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ*WIDTH-1:0] s_data,
    input  logic [N_REQ-1:0]       s_valid,
    input  logic [N_REQ-1:0]       s_last,
    output logic [N_REQ-1:0]       s_ready,
    output logic [WIDTH-1:0]       dout,
    output logic                   wren,
    input  logic                   full,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = cnt_width(MAX_BLOCK_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BLOCK_SIZE - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [N_REQ-1:0] r_grant;
    logic [PTR_W-1:0] r_owner;
    logic [PTR_W-1:0] r_last_owner;
    logic [CNT_W-1:0] r_cnt;

    logic [N_REQ-1:0] w_sel;
    logic             w_any;
    logic [PTR_W-1:0] w_sel_idx;
    logic             w_accept;
    logic             w_release;

    rr_pick #(
        .N_REQ(N_REQ),
        .PTR_W(PTR_W)
    ) u_pick (
        .req(s_valid),
        .ptr(r_last_owner),
        .sel(w_sel),
        .any(w_any)
    );

    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel[i]) w_sel_idx = PTR_W'(i);
        end
    end

    // rst gates the write path directly so a block in flight stops in the reset cycle.
    assign w_accept  = !rst && (r_state == ST_GRANT) && s_valid[r_owner] && !full;
    assign w_release = w_accept && (s_last[r_owner] || (r_cnt == CNT_LAST));

    assign s_ready = r_grant & {N_REQ{w_accept}};
    assign wren    = w_accept;
    assign dout    = s_data[r_owner*WIDTH +: WIDTH];
    assign grant   = r_grant;
    assign busy    = (r_state == ST_GRANT);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any) w_state_nxt = ST_GRANT;
            ST_GRANT: if (w_release) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= PTR_W'(N_REQ - 1);
            r_cnt        <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_sel;
                        r_owner <= w_sel_idx;
                        r_cnt   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_grant      <= '0;
                        r_last_owner <= r_owner;
                        r_cnt        <= '0;
                    end else if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench: vector table, directed scenarios, random vs reference model
module tb_fifo_write_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           full;
    logic [N*W-1:0] s_data;
    logic [N-1:0]   s_valid;
    logic [N-1:0]   s_last;
    logic [N-1:0]   s_ready;
    logic [W-1:0]   dout;
    logic           wren;
    logic [N-1:0]   grant;
    logic           busy;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .WIDTH(W),
        .N_REQ(N),
        .MAX_BLOCK_SIZE(MB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_last(s_last),
        .s_ready(s_ready),
        .dout(dout),
        .wren(wren),
        .full(full),
        .grant(grant),
        .busy(busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic        r;
        logic        f;
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        logic        e_wren;
        logic [7:0]  e_dout;
        logic [3:0]  e_ready;
        logic [3:0]  e_grant;
        logic        e_busy;
    } vec_t;

    vec_t tv[9];

    // Requester word queues {last, data}; model state is in requester-number terms.
    logic [8:0] q [N][$];
    int         m_owner;
    int         m_last;
    int         m_words;
    int         log_req[$];
    logic [7:0] log_dat[$];

    function automatic int idx_of(input logic [3:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic push_block(input int r, input logic [7:0] base, input int n, input logic with_last);
        for (int j = 0; j < n; j++) q[r].push_back({with_last && (j == n - 1), base + 8'(j)});
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) q[i].delete();
        log_req.delete();
        log_dat.delete();
    endtask

    task automatic drive(input logic r, input logic f, input logic [3:0] mask);
        rst  = r;
        full = f;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0 && mask[i]) begin
                s_valid[i]       = 1'b1;
                s_last[i]        = q[i][0][8];
                s_data[i*W +: W] = q[i][0][7:0];
            end else begin
                s_valid[i]       = 1'b0;
                s_last[i]        = 1'b0;
                s_data[i*W +: W] = 8'h00;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic f, input logic [3:0] mask);
        int         k;
        logic       acc;
        logic [3:0] e_ready;
        logic [8:0] w;
        drive(r, f, mask);
        @(negedge clk);
        k       = m_owner;
        acc     = !r && (k >= 0) && s_valid[k] && !f;
        e_ready = acc ? 4'(1 << k) : 4'b0000;
        w       = 9'h000;
        chk("wren", 32'(wren), 32'(acc));
        chk("s_ready", 32'(s_ready), 32'(e_ready));
        if (wren) begin
            log_req.push_back(idx_of(grant));
            log_dat.push_back(dout);
        end
        if (acc) begin
            w = q[k].pop_front();
            chk("dout", 32'(dout), 32'(w[7:0]));
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_owner = -1;
            m_last  = N - 1;
            m_words = 0;
        end else if (m_owner < 0) begin
            for (int j = 1; j <= N; j++) begin
                if (m_owner < 0 && s_valid[(m_last + j) % N]) begin
                    m_owner = (m_last + j) % N;
                    m_words = 0;
                end
            end
        end else if (acc) begin
            m_words++;
            if (w[8] || m_words == MB) begin
                m_last  = k;
                m_owner = -1;
            end
        end
        chk("grant", 32'(grant), (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'b1111);
    endtask

    initial begin
        int n0;
        tv[0] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0};
        tv[1] = '{1'b0, 1'b0, 4'b0001, 4'b0000, 32'h0000_0011, 1'b0, 8'h00, 4'b0000, 4'b0001, 1'b1};
        tv[2] = '{1'b0, 1'b0, 4'b0001, 4'b0000, 32'h0000_0011, 1'b1, 8'h11, 4'b0001, 4'b0001, 1'b1};
        tv[3] = '{1'b0, 1'b0, 4'b0001, 4'b0000, 32'h0000_0022, 1'b1, 8'h22, 4'b0001, 4'b0001, 1'b1};
        tv[4] = '{1'b0, 1'b0, 4'b0001, 4'b0001, 32'h0000_0033, 1'b1, 8'h33, 4'b0001, 4'b0000, 1'b0};
        tv[5] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0};
        tv[6] = '{1'b0, 1'b0, 4'b0010, 4'b0010, 32'h0000_4400, 1'b0, 8'h00, 4'b0000, 4'b0010, 1'b1};
        tv[7] = '{1'b0, 1'b1, 4'b0010, 4'b0010, 32'h0000_4400, 1'b0, 8'h00, 4'b0000, 4'b0010, 1'b1};
        tv[8] = '{1'b0, 1'b0, 4'b0010, 4'b0010, 32'h0000_4400, 1'b1, 8'h44, 4'b0010, 4'b0000, 1'b0};

        rst = 1'b1; full = 1'b0; s_valid = '0; s_last = '0; s_data = '0;
        m_owner = -1; m_last = N - 1; m_words = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            rst = tv[i].r; full = tv[i].f; s_valid = tv[i].v; s_last = tv[i].l; s_data = tv[i].d;
            @(negedge clk);
            chk($sformatf("vec%0d_wren", i), 32'(wren), 32'(tv[i].e_wren));
            chk($sformatf("vec%0d_ready", i), 32'(s_ready), 32'(tv[i].e_ready));
            if (tv[i].e_wren) chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(tv[i].e_dout));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tv[i].e_grant));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tv[i].e_busy));
        end

        // Round robin with all four continuously valid, 2-word blocks.
        clear_all();
        cyc(1'b1, 1'b0, 4'b1111);
        for (int i = 0; i < N; i++) begin
            push_block(i, 8'(8'h10 * (i + 1)), 2, 1'b1);
            push_block(i, 8'(8'h10 * (i + 1) + 8'h08), 2, 1'b1);
        end
        run(30);
        chk("rr_len", 32'(log_req.size()), 32'd16);
        for (int b = 0; b < 5; b++)
            if (2 * b < log_req.size()) chk($sformatf("rr_owner%0d", b), 32'(log_req[2*b]), 32'(b % N));

        // full held for 5 cycles before word 2 of 4.
        clear_all();
        cyc(1'b1, 1'b0, 4'b1111);
        push_block(0, 8'hA0, 4, 1'b1);
        run(2);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 4'b1111);
        run(5);
        chk("full_len", 32'(log_dat.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < log_dat.size()) chk($sformatf("full_word%0d", i), 32'(log_dat[i]), 32'(8'hA0 + i));

        // Block capped at MB words, then the other requester, then resume.
        clear_all();
        cyc(1'b1, 1'b0, 4'b1111);
        push_block(1, 8'h50, 10, 1'b0);
        push_block(2, 8'hC0, 2, 1'b1);
        run(25);
        chk("max_len", 32'(log_dat.size()), 32'd12);
        if (log_dat.size() >= 7) begin
            chk("max_w3", 32'(log_dat[3]), 32'h53);
            chk("max_other", 32'(log_dat[4]), 32'hC0);
            chk("max_resume", 32'(log_dat[6]), 32'h54);
            chk("max_resume_req", 32'(log_req[6]), 32'd1);
        end

        // Owner drops valid for 3 cycles; grant must be held.
        clear_all();
        cyc(1'b1, 1'b0, 4'b1111);
        push_block(0, 8'h30, 4, 1'b1);
        push_block(1, 8'h60, 2, 1'b1);
        push_block(3, 8'h70, 2, 1'b1);
        run(2);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'b1110);
        run(12);
        chk("drop_len", 32'(log_req.size()), 32'd8);
        for (int i = 0; i < 5; i++)
            if (i < log_req.size()) chk($sformatf("drop_req%0d", i), 32'(log_req[i]), (i < 4) ? 32'd0 : 32'd1);

        // Reset during word 3 of 6 owned by requester 2.
        clear_all();
        cyc(1'b1, 1'b0, 4'b1111);
        push_block(2, 8'h80, 6, 1'b1);
        push_block(0, 8'h20, 2, 1'b1);
        push_block(3, 8'hE0, 2, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'b0100);
        n0 = log_dat.size();
        cyc(1'b1, 1'b0, 4'b0100);
        chk("rst_words", 32'(log_dat.size()), 32'(n0));
        cyc(1'b0, 1'b0, 4'b1101);
        chk("rst_restart", 32'(grant), 32'b0001);
        run(6);
        if (log_dat.size() > n0) chk("rst_first", 32'(log_dat[n0]), 32'h20);
        else chk("rst_first", 32'hFFFF_FFFF, 32'h20);

        // Random traffic against the model.
        clear_all();
        cyc(1'b1, 1'b0, 4'b1111);
        for (int c = 0; c < 600; c++) begin
            logic [3:0] mask;
            for (int i = 0; i < N; i++) begin
                if (q[i].size() == 0 && $urandom_range(0, 3) == 0)
                    push_block(i, 8'($urandom), int'($urandom_range(1, 6)), 1'b1);
                mask[i] = ($urandom_range(0, 5) != 0);
            end
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, mask);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Shares the single write port of a synchronous FIFO between `N_REQ` block-oriented requesters. Grants one requester at a time in round-robin order and holds the grant for a whole block, until that requester's `last` word or `MAX_BLOCK_SIZE` words. Forwards the granted stream to the FIFO's `dout`/`wren` while honouring `full`. It sits between the bench and DMA-style producers and the FIFO write side, and replaces per-producer writers.

## Interface

Parameters
- `WIDTH`, 8, data word width.
- `N_REQ`, 4, number of requesters, ≥2.
- `MAX_BLOCK_SIZE`, 1024, maximum words per grant, ≥1.

Ports
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_data`  in  `N_REQ*WIDTH`  requester words; requester i occupies `[i*WIDTH +: WIDTH]`.
- `s_valid`  in  `N_REQ`  requester i has a word.
- `s_last`  in  `N_REQ`  the word is the last of its block.
- `s_ready`  out  `N_REQ`  word of requester i accepted this cycle.
- `dout`  out  `WIDTH`  FIFO write data.
- `wren`  out  1  FIFO write enable.
- `full`  in  1  FIFO full.
- `grant`  out  `N_REQ`  one-hot current owner; all zero when idle.
- `busy`  out  1  a grant is held.

## Operation

- The state machine has two states, IDLE and GRANT.
- IDLE:
  - If any `s_valid` bit is set, pick the first set bit searching upward from `last_owner+1`, modulo `N_REQ`.
  - Register the winner into `grant`, clear the word counter, and go to GRANT.
  - Otherwise stay in IDLE.
  - No words are written in IDLE.
- GRANT, with owner k:
  - `s_ready[k] = s_valid[k] & ~full`. All other `s_ready` bits are 0.
  - `wren = s_ready[k]`, and `dout = s_data[k]`.
  - Each accepted word increments the counter.
  - Release happens when an accepted word has `s_last[k]=1`, or when the counter reaches `MAX_BLOCK_SIZE-1`. The counter is at that value when the word is accepted, so exactly `MAX_BLOCK_SIZE` words have been written.
  - On release: `last_owner <= k`, `grant <= 0`, go to IDLE.
- If the owner deasserts `s_valid` mid-block, the grant is held indefinitely and `wren=0`. There is no timeout.
- `s_valid`/`s_last` of non-owners are ignored. Requesters hold data and valid until `s_ready`.
- `full` blocks acceptance only; it never releases a grant.
- Counter width is `$clog2(MAX_BLOCK_SIZE)`, with a minimum of 1 bit. When `MAX_BLOCK_SIZE=1`, every accepted word releases.
- Reset values:
  - state IDLE; `grant=0`; `busy=0`; counter 0.
  - `last_owner=N_REQ-1`, so requester 0 wins first.
  - While `rst` is high, `wren=0` and `s_ready=0`.
- Reset mid-block: the block is abandoned. The FIFO receives no further words of it, and arbitration restarts from requester 0.

## Timing

- `dout`, `wren` and `s_ready` are combinational from `grant`, `s_valid`, `s_data` and `full`. They have no register stage.
- `grant` and `busy` are registered.
- Latency:
  - A request first seen in IDLE at edge t gets `grant` after edge t.
  - Its first write can occur in the cycle following edge t.
- Release bubble: after the releasing word, there is exactly one IDLE cycle with `wren=0` before the next owner writes.
- Back-to-back ownership:
  - A requester may win again if it is the only one valid.
  - Otherwise round-robin guarantees that every other valid requester is served before it.
- `full` rising in the same cycle as the owner's `last`: the word is not accepted and the grant is kept.

## Structure

- A shared package or header holds:
  - the state encoding constants (IDLE=0, GRANT=1);
  - the counter-width function.
- One sub-module, `rr_pick`, which is purely combinational:
  - inputs: `req[N_REQ]` and the pointer;
  - output: a one-hot `sel` plus an `any` flag;
  - searches modulo `N_REQ` starting from pointer+1.
- Counter, state register, `last_owner` and the output mux live in `fifo_write_arbiter`.

## Test plan

- Reset, then requester 0 valid with a 3-word block (0x11, 0x22, 0x33 last), `full=0`:
  - `grant=0001` one cycle after the request;
  - 3 consecutive writes of 0x11, 0x22, 0x33;
  - `busy` drops after 0x33.
- All 4 requesters continuously valid with 2-word blocks:
  - owners in order 0, 1, 2, 3, 0;
  - exactly one `wren=0` bubble between blocks.
- `full` held high for 5 cycles mid-block at word 2 of 4:
  - `wren=0` and `s_ready=0` for those 5 cycles;
  - the grant is unchanged;
  - word 2 is written on the first cycle after `full` drops;
  - no duplicated or lost words.
- `MAX_BLOCK_SIZE=4`, requester 1 streaming 10 words with no `last`, requester 2 valid:
  - requester 1 writes 4 words;
  - then requester 2 gets its block;
  - then requester 1 resumes at word 5.
- Owner drops `s_valid` for 3 cycles mid-block while others request:
  - the grant is held and `wren=0`;
  - the owner resumes and completes, and only then do others win.
- `rst` asserted during word 3 of 6:
  - `wren=0` from that cycle on, and `grant=0` after the edge;
  - after release, requester 0 is granted first even if the previous owner was 2.
